// File: rtl/hilo_mudi_ctrl.sv
// Multiply/divide sequencer and HI/LO register owner beside the EX stage.
// Define MUL_ITER_EN for a 32-cycle shift-add multiplier; otherwise the product is formed in one cycle.
module hilo_mudi_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        es_valid,
    input  logic [3:0]  es_mudi,
    input  logic        es_mthi,
    input  logic        es_mtlo,
    input  logic [31:0] es_src1,
    input  logic [31:0] es_src2,
    input  logic        es_cancel,
    output logic        es_mudi_stall,
    output logic        busy,
    output logic [31:0] hi_rdata,
    output logic [31:0] lo_rdata
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] acc_hi;     // partial remainder / product upper half
    logic [31:0] acc_lo;     // quotient shift register / product lower half
    logic [31:0] opb;        // divisor or multiplicand
    logic        neg_q;
    logic        neg_r;
    logic        is_div;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        req;
    logic        signed_op;
    logic        sign1;
    logic        sign2;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] trial;
    logic [63:0] product;
    logic [63:0] product_fix;
    logic [31:0] res_hi;
    logic [31:0] res_lo;
`ifdef MUL_ITER_EN
    logic [32:0] mul_sum;
`else
    logic [63:0] wide_prod;
`endif

    assign req       = es_valid & (|es_mudi) & ~es_cancel;
    assign signed_op = es_mudi[0] | es_mudi[2];
    assign sign1     = signed_op & es_src1[31];
    assign sign2     = signed_op & es_src2[31];
    // 0x80000000 negates to itself, which read unsigned is the correct magnitude.
    assign abs1      = sign1 ? (32'd0 - es_src1) : es_src1;
    assign abs2      = sign2 ? (32'd0 - es_src2) : es_src2;

    // Reset gates the stall so a held EX request cannot stall the pipe while in reset.
    assign es_mudi_stall = resetn & es_valid & (|es_mudi) & ~es_cancel & (state != DONE);
    assign hi_rdata      = hi;
    assign lo_rdata      = lo;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        trial       = {acc_hi, acc_lo[31]} - {1'b0, opb};
        product     = {acc_hi, acc_lo};
        product_fix = neg_q ? (64'd0 - product) : product;
        res_hi      = product_fix[63:32];
        res_lo      = product_fix[31:0];
        if (is_div) begin
            res_hi = neg_r ? (32'd0 - acc_hi) : acc_hi;
            res_lo = neg_q ? (32'd0 - acc_lo) : acc_lo;
        end
`ifdef MUL_ITER_EN
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);
`else
        wide_prod = {32'd0, abs1} * {32'd0, abs2};
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            busy   <= 1'b0;
            cnt    <= 5'd0;
            acc_hi <= 32'd0;
            acc_lo <= 32'd0;
            opb    <= 32'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            is_div <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
        end else if (es_cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        neg_q  <= sign1 ^ sign2;
                        neg_r  <= sign1;
                        is_div <= es_mudi[2] | es_mudi[3];
                        cnt    <= 5'd31;
                        busy   <= 1'b1;
                        if (es_mudi[2] | es_mudi[3]) begin
                            acc_hi <= 32'd0;
                            acc_lo <= abs1;
                            opb    <= abs2;
                            state  <= DIV;
                        end else begin
`ifdef MUL_ITER_EN
                            acc_hi <= 32'd0;
                            acc_lo <= abs2;
                            opb    <= abs1;
                            state  <= MUL;
`else
                            acc_hi <= wide_prod[63:32];
                            acc_lo <= wide_prod[31:0];
                            state  <= DONE;
`endif
                        end
                    end else if (es_valid) begin
                        if (es_mthi) hi <= es_src1;
                        if (es_mtlo) lo <= es_src1;
                    end
                end
                MUL: begin
`ifdef MUL_ITER_EN
                    acc_hi <= mul_sum[32:1];
                    acc_lo <= {mul_sum[0], acc_lo[31:1]};
                    cnt    <= cnt - 5'd1;
                    if (cnt == 5'd0) state <= DONE;
`else
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                DIV: begin
                    // Restore by keeping the shifted remainder when the trial subtraction goes negative.
                    if (!trial[32]) begin
                        acc_hi <= trial[31:0];
                        acc_lo <= {acc_lo[30:0], 1'b1};
                    end else begin
                        acc_hi <= {acc_hi[30:0], acc_lo[31]};
                        acc_lo <= {acc_lo[30:0], 1'b0};
                    end
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) state <= DONE;
                end
                DONE: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_mudi_ctrl.sv
// Directed self-checking bench for hilo_mudi_ctrl: divide, multiply, mthi/mtlo, cancel and async reset.
module tb_hilo_mudi_ctrl;

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0100;
    localparam logic [3:0] OP_DIVU  = 4'b1000;

`ifdef MUL_ITER_EN
    localparam int MUL_STALL = 33;
`else
    localparam int MUL_STALL = 1;
`endif

    logic        clk;
    logic        resetn;
    logic        es_valid;
    logic [3:0]  es_mudi;
    logic        es_mthi;
    logic        es_mtlo;
    logic [31:0] es_src1;
    logic [31:0] es_src2;
    logic        es_cancel;
    logic        es_mudi_stall;
    logic        busy;
    logic [31:0] hi_rdata;
    logic [31:0] lo_rdata;

    int errors = 0;
    int checks = 0;
    int stalls;

    hilo_mudi_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .es_valid      (es_valid),
        .es_mudi       (es_mudi),
        .es_mthi       (es_mthi),
        .es_mtlo       (es_mtlo),
        .es_src1       (es_src1),
        .es_src2       (es_src2),
        .es_cancel     (es_cancel),
        .es_mudi_stall (es_mudi_stall),
        .busy          (busy),
        .hi_rdata      (hi_rdata),
        .lo_rdata      (lo_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues an op at the current cycle, counts stall cycles, then waits for the commit edge.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_stall, input logic [63:0] exp_hilo);
        int n;
        es_valid = 1'b1;
        es_mudi  = op;
        es_src1  = a;
        es_src2  = b;
        n = 0;
        #1;
        while (es_mudi_stall && n < 100) begin
            n++;
            step();
        end
        check({tag, "_stall_cycles"}, 64'(n), 64'(exp_stall));
        check({tag, "_busy_in_done"}, 64'(busy), 64'd1);
        step();
        es_valid = 1'b0;
        es_mudi  = 4'd0;
        check({tag, "_hilo"}, {hi_rdata, lo_rdata}, exp_hilo);
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        resetn    = 1'b0;
        es_valid  = 1'b0;
        es_mudi   = 4'd0;
        es_mthi   = 1'b0;
        es_mtlo   = 1'b0;
        es_src1   = 32'd0;
        es_src2   = 32'd0;
        es_cancel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hilo",  {hi_rdata, lo_rdata}, 64'd0);
        check("reset_busy",  64'(busy), 64'd0);
        check("reset_stall", 64'(es_mudi_stall), 64'd0);
        resetn = 1'b1;
        step();

        run_op("div_7_m2",     OP_DIV,   32'd7,        32'hFFFF_FFFE, 33, 64'h00000001_FFFFFFFD);
        run_op("div_m7_2",     OP_DIV,   32'hFFFF_FFF9, 32'd2,        33, 64'hFFFFFFFF_FFFFFFFD);
        run_op("divu_big",     OP_DIVU,  32'hFFFF_FFFF, 32'h10,       33, 64'h0000000F_0FFFFFFF);
        run_op("div_by_zero",  OP_DIV,   32'd5,        32'd0,        33, 64'h00000005_FFFFFFFF);
        run_op("mult_min",     OP_MULT,  32'h8000_0000, 32'h8000_0000, MUL_STALL, 64'h40000000_00000000);
        run_op("mult_m1",      OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_STALL, 64'h00000000_00000001);
        run_op("multu_max",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_STALL, 64'hFFFFFFFE_00000001);
        run_op("mult_neg",     OP_MULT,  32'hFFFF_FFFD, 32'd7,        MUL_STALL, 64'hFFFFFFFF_FFFFFFEB);

        // Cancel a div in flight; HI/LO still hold the last mult result.
        es_valid = 1'b1;
        es_mudi  = OP_DIV;
        es_src1  = 32'd100;
        es_src2  = 32'd3;
        repeat (10) step();
        es_cancel = 1'b1;
        #1;
        check("cancel_stall_same_cycle", 64'(es_mudi_stall), 64'd0);
        check("cancel_busy_before_edge", 64'(busy), 64'd1);
        step();
        es_cancel = 1'b0;
        check("cancel_busy_next", 64'(busy), 64'd0);
        check("cancel_hilo_kept", {hi_rdata, lo_rdata}, 64'hFFFFFFFF_FFFFFFEB);
        run_op("divu_after_cancel", OP_DIVU, 32'd9, 32'd2, 33, 64'h00000001_00000004);

        // mthi then mtlo in consecutive cycles, never stalling.
        es_valid = 1'b1;
        es_mthi  = 1'b1;
        es_src1  = 32'h1234_5678;
        #1;
        check("mthi_no_stall", 64'(es_mudi_stall), 64'd0);
        step();
        check("mthi_hi", 64'(hi_rdata), 64'h12345678);
        check("mthi_lo_kept", 64'(lo_rdata), 64'h00000004);
        es_mthi = 1'b0;
        es_mtlo = 1'b1;
        es_src1 = 32'h9ABC_DEF0;
        #1;
        check("mtlo_no_stall", 64'(es_mudi_stall), 64'd0);
        step();
        check("mtlo_hilo", {hi_rdata, lo_rdata}, 64'h12345678_9ABCDEF0);

        // A cancelled mthi must not write HI.
        es_mtlo   = 1'b0;
        es_mthi   = 1'b1;
        es_cancel = 1'b1;
        es_src1   = 32'hDEAD_BEEF;
        step();
        check("mthi_cancelled", 64'(hi_rdata), 64'h12345678);
        es_mthi   = 1'b0;
        es_cancel = 1'b0;
        es_valid  = 1'b0;

        // Asynchronous reset in the middle of a division.
        es_valid = 1'b1;
        es_mudi  = OP_DIV;
        es_src1  = 32'd1000;
        es_src2  = 32'd7;
        repeat (20) step();
        check("pre_reset_busy", 64'(busy), 64'd1);
        resetn = 1'b0;
        #1;
        check("async_reset_hilo",  {hi_rdata, lo_rdata}, 64'd0);
        check("async_reset_busy",  64'(busy), 64'd0);
        check("async_reset_stall", 64'(es_mudi_stall), 64'd0);
        es_valid = 1'b0;
        es_mudi  = 4'd0;
        #1;
        resetn = 1'b1;
        step();
        check("post_reset_busy", 64'(busy), 64'd0);
        run_op("divu_after_reset", OP_DIVU, 32'd17, 32'd5, 33, 64'h00000002_00000003);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hilo_mudi_ctrl.md
# hilo_mudi_ctrl

Multiply/divide sequencer and HI/LO register owner for the five-stage MIPS pipeline. Sits beside the execute stage. It accepts mult/multu/div/divu/mthi/mtlo from EX, runs multi-cycle operations on its internal shift-add/restoring datapath, stalls EX until the result is committed, and supplies HI/LO to mfhi/mflo.

## Interface
- No parameters; width fixed at 32.
- `clk  in  1` — pipeline clock.
- `resetn  in  1` — asynchronous, active-low reset.
- `es_valid  in  1` — EX holds a valid instruction.
- `es_mudi  in  4` — one-hot {divu, div, multu, mult}; all zero for other instructions.
- `es_mthi  in  1` — EX instruction is mthi.
- `es_mtlo  in  1` — EX instruction is mtlo.
- `es_src1  in  32` — rs value: dividend, multiplicand, or mthi/mtlo data.
- `es_src2  in  32` — rt value: divisor or multiplier.
- `es_cancel  in  1` — flush of the EX instruction; aborts any operation in flight.
- `es_mudi_stall  out  1` — EX must hold; combinational.
- `busy  out  1` — state is not IDLE; registered.
- `hi_rdata  out  32` — current HI register.
- `lo_rdata  out  32` — current LO register.

## Operation
- Reset values: state IDLE, HI = 0, LO = 0, counter 0, `busy` = 0, `es_mudi_stall` = 0.
- States: IDLE, MUL, DIV, DONE.
- `req` = `es_valid & |es_mudi & !es_cancel`.
- IDLE to DIV (div/divu) or MUL (mult/multu) on `req`:
  - Latch |src1| and |src2|. Absolute value is taken only for signed ops. |0x80000000| = 0x80000000, read unsigned.
  - Latch sign flags: quotient/product negative = sign1 ^ sign2; remainder negative = sign1.
  - Counter = 31.
- DIV: restoring division, one quotient bit per cycle, MSB first.
  - 33-bit partial remainder. Subtract the divisor when the trial result is non-negative; quotient bit = 1 in that case.
  - Counter decrements each cycle. Counter = 0 → DONE.
- MUL: see Configuration.
- DONE: apply sign fixups (two's-complement negate where the flag is set). On the clock edge leaving DONE, write LO = quotient / product[31:0] and HI = remainder / product[63:32]. Next state IDLE.
- Divide by zero is not trapped. Result: unsigned quotient 0xFFFFFFFF, remainder = |dividend|, then sign fixups are applied. This is deterministic and checked.
- `es_mudi_stall` = `es_valid & |es_mudi & !es_cancel & (state != DONE)`. It is 1 in the IDLE request cycle and throughout MUL/DIV, and 0 in DONE, so EX advances exactly as the result commits.
- mthi/mtlo:
  - Acted on only in IDLE, when `es_valid & !es_cancel & es_mudi == 0`.
  - HI or LO ← `es_src1` at the next edge. No stall.
  - If `es_mudi` is nonzero, mthi/mtlo are ignored (mudi has priority).
- `es_cancel` in any state:
  - Next state IDLE; HI/LO are not written.
  - Stall deasserts in the same cycle.
  - A request in the following cycle is accepted normally.
- `resetn` low mid-operation: immediate return to reset values.

## Timing
- Request seen in IDLE at cycle T.
- div/divu: DIV for cycles T+1..T+32, DONE at T+33. Stall high T..T+32. HI/LO updated at the T+33→T+34 edge and visible at T+34.
- mthi/mtlo at cycle T: new value visible at T+1.
- `hi_rdata`/`lo_rdata` are direct register outputs. The mfhi following a mudi reaches EX at T+34 or later, so no bypass is needed.
- No back-to-back acceptance: DONE always returns to IDLE before a new request is latched.

## Configuration
- `MUL_ITER_EN` defined:
  - mult/multu use an iterative shift-add on the shared 32-cycle counter: add the multiplicand when the multiplier LSB = 1, shift the 64-bit accumulator right.
  - Timing is identical to div: 34 cycles to visibility, stall T..T+32.
- `MUL_ITER_EN` undefined:
  - The product |src1|·|src2| is computed combinationally and registered at T. State goes IDLE → DONE directly, skipping MUL.
  - Stall high only at T; DONE at T+1; HI/LO visible at T+2.
  - The MUL state is unreachable.

## Test plan
- div src1 = 7, src2 = 0xFFFFFFFE (−2) → LO = 0xFFFFFFFD, HI = 0x00000001, visible at T+34. Stall high for exactly 33 cycles.
- divu 0xFFFFFFFF / 0x00000010 → LO = 0x0FFFFFFF, HI = 0x0000000F. div 5 / 0 → LO = 0xFFFFFFFF, HI = 0x00000005.
- mult 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0x00000000. mult 0xFFFFFFFF × 0xFFFFFFFF → HI = 0, LO = 1. multu 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 1. Latency checked both with and without `MUL_ITER_EN`.
- Start div 100/3, assert `es_cancel` at T+10 → stall 0 in the same cycle, IDLE next cycle, HI/LO unchanged. A new divu 9/2 issued at T+11 yields LO = 4, HI = 1.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 in consecutive cycles → `hi_rdata`/`lo_rdata` updated at T+1/T+2, no stall.
- Pull `resetn` low at DIV cycle 20 → HI = LO = 0, `busy` = 0, `es_mudi_stall` = 0 immediately (asynchronous).
